// File: rtl/flush_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flush_redirect_ctrl_pkg
// Brief    : Shared constants, FSM state encoding and redirect target helper
//            for the flush/redirect sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package flush_redirect_ctrl_pkg;

  // Exception code that vectors to the TLB-refill entry instead of EENTRY.
  localparam logic [5:0] c_ecode_tlbr_dflt = 6'h3F;

  // Sequencer states: idle, waiting for stale fetch responses, offering PC.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_REDIR = 2'b10
  } frc_state_e;

  // Redirect target: exception beats ertn beats refetch.
  function automatic logic [31:0] frc_sel_target(
    input logic        ex,
    input logic        ertn,
    input logic [5:0]  ecode,
    input logic [5:0]  ecode_tlbr,
    input logic [31:0] pc,
    input logic [31:0] eentry,
    input logic [31:0] tlbrentry,
    input logic [31:0] era
  );
    logic [31:0] tgt;
    if (ex) begin
      tgt = (ecode == ecode_tlbr) ? tlbrentry : eentry;
    end else if (ertn) begin
      tgt = era;
    end else begin
      tgt = pc + 32'd4;
    end
    return tgt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flush_redirect_ctrl_outst_tracker.sv
`default_nettype none
// ============================================================================
// Module   : flush_redirect_ctrl_outst_tracker
// Brief    : Counts in-flight instruction reads and how many of them are stale
//            after a flush, and flags responses that must be discarded.
// Revision : 1.0 - initial release
// ============================================================================
module flush_redirect_ctrl_outst_tracker
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = 3,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             trig,
  input  logic             inst_req_fire,
  input  logic             inst_resp_fire,
  output logic [CNT_W-1:0] outst_cnt_next,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             outst_full,
  output logic             inst_resp_drop
);

  localparam logic [CNT_W-1:0] c_max_outst = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] r_outst_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_outst_cnt_next;
  logic             w_drop_pending;

  // Next in-flight count and the drop decision for the current response.
  always_comb begin
    w_outst_cnt_next = r_outst_cnt + CNT_W'(inst_req_fire) - CNT_W'(inst_resp_fire);
    w_drop_pending   = (r_drop_cnt != '0);
  end

  // A flush makes every transaction still in flight after this cycle stale,
  // including a request accepted in the flush cycle itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outst_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_outst_cnt <= w_outst_cnt_next;
      if (trig) begin
        r_drop_cnt <= w_outst_cnt_next;
      end else if (inst_resp_fire && w_drop_pending) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  assign outst_cnt_next = w_outst_cnt_next;
  assign drop_cnt       = r_drop_cnt;
  assign outst_full     = (r_outst_cnt == c_max_outst);
  assign inst_resp_drop = inst_resp_fire & (trig | w_drop_pending);

  // Bus protocol sanity: no response without a request, no request past the limit.
  a_no_resp_underflow : assert property (@(posedge clk) disable iff (!resetn)
    !(inst_resp_fire && (r_outst_cnt == '0)));
  a_no_req_overflow : assert property (@(posedge clk) disable iff (!resetn)
    !(inst_req_fire && (r_outst_cnt == c_max_outst)));

endmodule
`default_nettype wire

// File: rtl/flush_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flush_redirect_ctrl
// Brief    : Central flush/redirect sequencer. Flushes the pipeline on a
//            writeback event, drains stale fetch responses, then hands the new
//            fetch PC to the fetch stage with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int         MAX_OUTST  = 3,
  parameter int         CNT_W      = 2,
  parameter logic [5:0] ECODE_TLBR = c_ecode_tlbr_dflt
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        wb_refetch_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_tlbrentry,
  input  logic [31:0] csr_era,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  output logic        flush,
  output logic        inst_resp_drop,
  output logic        fetch_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  frc_state_e       r_state;
  frc_state_e       w_state_next;
  logic [31:0]      r_tgt_pc;
  logic [31:0]      w_tgt_sel;
  logic             w_trig;
  logic [CNT_W-1:0] w_outst_cnt_next;
  logic [CNT_W-1:0] w_drop_cnt;
  logic             w_outst_full;

  assign w_trig    = wb_ex | ertn_flush | wb_refetch_flush;
  assign w_tgt_sel = frc_sel_target(wb_ex, ertn_flush, wb_ecode, ECODE_TLBR, wb_pc,
                                    csr_eentry, csr_tlbrentry, csr_era);

  flush_redirect_ctrl_outst_tracker #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_outst_tracker (
    .clk            (clk),
    .resetn         (resetn),
    .trig           (w_trig),
    .inst_req_fire  (inst_req_fire),
    .inst_resp_fire (inst_resp_fire),
    .outst_cnt_next (w_outst_cnt_next),
    .drop_cnt       (w_drop_cnt),
    .outst_full     (w_outst_full),
    .inst_resp_drop (inst_resp_drop)
  );

  // State register and redirect target latch; a trigger always reloads both.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_tgt_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_trig) begin
        r_tgt_pc <= w_tgt_sel;
      end
    end
  end

  // Next state and sequencer outputs; a trigger restarts from any state.
  always_comb begin
    w_state_next   = r_state;
    redirect_valid = 1'b0;
    busy           = 1'b0;
    fetch_stall    = w_outst_full | w_trig;
    if (w_trig) begin
      w_state_next = (w_outst_cnt_next != '0) ? ST_DRAIN : ST_REDIR;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_IDLE;
        ST_DRAIN: begin
          if (inst_resp_fire && (w_drop_cnt == CNT_W'(1))) begin
            w_state_next = ST_REDIR;
          end
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
    case (r_state)
      ST_DRAIN: begin
        busy        = 1'b1;
        fetch_stall = 1'b1;
      end
      ST_REDIR: begin
        busy           = 1'b1;
        fetch_stall    = 1'b1;
        redirect_valid = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign flush       = w_trig;
  assign redirect_pc = r_tgt_pc;

endmodule
`default_nettype wire

// File: tb/tb_flush_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flush_redirect_ctrl
// Brief    : Scoreboard bench for flush_redirect_ctrl with a transaction-level
//            reference model (queue of in-flight fetches tagged stale/live).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flush_redirect_ctrl;

  localparam int MAX_OUTST = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_ex, ertn_flush, wb_refetch_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [31:0] csr_eentry, csr_tlbrentry, csr_era;
  logic        inst_req_fire, inst_resp_fire;
  logic        flush, inst_resp_drop, fetch_stall, redirect_valid, busy;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  always #5 clk = ~clk;

  flush_redirect_ctrl #(
    .MAX_OUTST  (MAX_OUTST),
    .CNT_W      (2),
    .ECODE_TLBR (6'h3F)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .wb_ex            (wb_ex),
    .ertn_flush       (ertn_flush),
    .wb_refetch_flush (wb_refetch_flush),
    .wb_pc            (wb_pc),
    .wb_ecode         (wb_ecode),
    .csr_eentry       (csr_eentry),
    .csr_tlbrentry    (csr_tlbrentry),
    .csr_era          (csr_era),
    .inst_req_fire    (inst_req_fire),
    .inst_resp_fire   (inst_resp_fire),
    .flush            (flush),
    .inst_resp_drop   (inst_resp_drop),
    .fetch_stall      (fetch_stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready),
    .busy             (busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          flush;
    bit          stall;
    bit          valid;
    bit          busy;
    logic [31:0] pc;
  } cyc_exp_t;

  cyc_exp_t    cyc_q[$];
  bit          drop_q[$];
  logic [31:0] redir_q[$];

  // Reference model: in-flight fetches oldest-first, 1 = stale.
  bit          m_outst[$];
  bit          m_pend;
  bit          m_avail;
  logic [31:0] m_tgt;
  bit          mon_en;

  // CSR values to present in the next driven cycle.
  logic [31:0] nx_eentry, nx_tlbrentry, nx_era;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  cyc_exp_t mon_e;
  always @(negedge clk) begin
    #2;
    if (mon_en && resetn) begin
      if (cyc_q.size() > 0) begin
        mon_e = cyc_q.pop_front();
        check("flush",          32'(flush),          32'(mon_e.flush));
        check("fetch_stall",    32'(fetch_stall),    32'(mon_e.stall));
        check("redirect_valid", 32'(redirect_valid), 32'(mon_e.valid));
        check("busy",           32'(busy),           32'(mon_e.busy));
        check("redirect_pc",    redirect_pc,         mon_e.pc);
      end
      if (inst_resp_fire) begin
        if (drop_q.size() == 0) check("drop_q_underrun", 32'd1, 32'd0);
        else check("inst_resp_drop", 32'(inst_resp_drop), 32'(drop_q.pop_front()));
      end
      if (redirect_valid && redirect_ready) begin
        if (redir_q.size() == 0) check("unexpected_redirect", redirect_pc, 32'hDEADBEEF);
        else check("redirect_handshake_pc", redirect_pc, redir_q.pop_front());
      end
    end
  end

  // Drives one cycle of stimulus and pushes the model's expectations for it.
  task automatic cyc(input bit ex, input bit er, input bit rf, input logic [31:0] pc,
                     input logic [5:0] ec, input bit req, input bit resp, input bit rdy);
    cyc_exp_t    e;
    bit          trig;
    bit          accepted;
    bit          any_stale;
    logic [31:0] tgt;
    @(negedge clk);
    if (m_outst.size() == 0) resp = 1'b0;
    if (m_outst.size() >= MAX_OUTST || m_pend) req = 1'b0;
    csr_eentry       = nx_eentry;
    csr_tlbrentry    = nx_tlbrentry;
    csr_era          = nx_era;
    wb_ex            = ex;
    ertn_flush       = er;
    wb_refetch_flush = rf;
    wb_pc            = pc;
    wb_ecode         = ec;
    inst_req_fire    = req;
    inst_resp_fire   = resp;
    redirect_ready   = rdy;
    trig    = ex | er | rf;
    e.flush = trig;
    e.valid = m_avail;
    e.busy  = m_pend;
    e.stall = (m_outst.size() == MAX_OUTST) || m_pend || trig;
    e.pc    = m_tgt;
    cyc_q.push_back(e);
    if (resp) begin
      drop_q.push_back(trig || m_outst[0]);
      void'(m_outst.pop_front());
    end
    if (req) m_outst.push_back(1'b0);
    accepted = m_avail && rdy;
    if (accepted) begin
      m_pend  = 1'b0;
      m_avail = 1'b0;
    end
    if (trig) begin
      if (ex) tgt = (ec == 6'h3F) ? csr_tlbrentry : csr_eentry;
      else if (er) tgt = csr_era;
      else tgt = pc + 32'd4;
      if (m_pend && redir_q.size() > 0) void'(redir_q.pop_back());
      redir_q.push_back(tgt);
      foreach (m_outst[i]) m_outst[i] = 1'b1;
      m_pend  = 1'b1;
      m_tgt   = tgt;
      m_avail = (m_outst.size() == 0);
    end else if (m_pend && !m_avail) begin
      any_stale = 1'b0;
      foreach (m_outst[i]) if (m_outst[i]) any_stale = 1'b1;
      m_avail = !any_stale;
    end
  endtask

  task automatic idle(input bit resp, input bit rdy);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 6'h0, 1'b0, resp, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flush"},          32'(flush),          32'd0);
    check({tag, "_inst_resp_drop"}, 32'(inst_resp_drop), 32'd0);
    check({tag, "_fetch_stall"},    32'(fetch_stall),    32'd0);
    check({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    check({tag, "_busy"},           32'(busy),           32'd0);
    check({tag, "_redirect_pc"},    redirect_pc,         32'd0);
  endtask

  task automatic model_clear();
    m_outst.delete();
    cyc_q.delete();
    drop_q.delete();
    redir_q.delete();
    m_pend  = 1'b0;
    m_avail = 1'b0;
    m_tgt   = 32'h0;
  endtask

  initial begin
    resetn = 1'b0; mon_en = 1'b0;
    wb_ex = 0; ertn_flush = 0; wb_refetch_flush = 0; wb_pc = 0; wb_ecode = 0;
    inst_req_fire = 0; inst_resp_fire = 0; redirect_ready = 0;
    csr_eentry = 32'h1C008000; csr_tlbrentry = 32'h1C00F000; csr_era = 32'h1C001234;
    nx_eentry = 32'h1C008000; nx_tlbrentry = 32'h1C00F000; nx_era = 32'h1C001234;
    model_clear();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Idle exception with nothing in flight.
    cyc(1, 0, 0, 32'h1C000100, 6'h0B, 0, 0, 0);
    idle(0, 0);
    idle(0, 1);
    idle(0, 0);

    // TLB refill with two fetches in flight.
    idle(0, 0);
    cyc(0, 0, 0, 32'h0, 6'h0, 1, 0, 0);
    cyc(0, 0, 0, 32'h0, 6'h0, 1, 0, 0);
    cyc(1, 0, 0, 32'h1C000200, 6'h3F, 0, 0, 0);
    idle(0, 0);
    idle(1, 0);
    idle(0, 0);
    idle(1, 0);
    idle(0, 1);
    idle(0, 0);

    // Refetch at the top of the address space wraps to zero.
    cyc(0, 0, 1, 32'hFFFFFFFC, 6'h0, 0, 0, 0);
    idle(0, 1);
    idle(0, 0);

    // Exception wins over a simultaneous ertn.
    cyc(1, 1, 0, 32'h1C000300, 6'h01, 0, 0, 0);
    idle(0, 1);
    idle(0, 0);

    // Trigger coinciding with a response and a new request.
    cyc(0, 0, 0, 32'h0, 6'h0, 1, 0, 0);
    cyc(0, 1, 0, 32'h1C000400, 6'h0, 1, 1, 0);
    idle(0, 0);
    idle(1, 0);
    idle(0, 1);
    idle(0, 0);

    // Retrigger while the redirect is offered but not yet taken.
    nx_era = 32'h1C001000;
    cyc(0, 1, 0, 32'h1C000500, 6'h0, 0, 0, 0);
    idle(0, 0);
    nx_era = 32'h1C002000;
    cyc(0, 1, 0, 32'h1C000504, 6'h0, 0, 0, 0);
    idle(0, 0);
    idle(0, 1);
    idle(0, 0);

    // Asynchronous reset in the middle of a drain.
    cyc(0, 0, 0, 32'h0, 6'h0, 1, 0, 0);
    cyc(0, 0, 0, 32'h0, 6'h0, 1, 0, 0);
    cyc(1, 0, 0, 32'h1C000600, 6'h0B, 0, 0, 0);
    idle(0, 0);
    @(negedge clk);
    wb_ex = 0; ertn_flush = 0; wb_refetch_flush = 0;
    inst_req_fire = 0; inst_resp_fire = 0; redirect_ready = 0;
    #4;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    idle(0, 0);
    idle(0, 1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      logic [5:0]  rec;
      nx_eentry    = $urandom;
      nx_tlbrentry = $urandom;
      nx_era       = $urandom;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      rec = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0, rpc, rec,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) != 0);
    end

    // Let any pending redirect complete, then confirm it was delivered.
    for (int n = 0; n < 40; n++) idle(1, 1);
    check("redir_q_drained", 32'(redir_q.size()), 32'd0);
    check("drop_q_drained",  32'(drop_q.size()),  32'd0);

    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
- Central flush/redirect sequencer for the 5-stage LoongArch pipeline.
- Consumes the writeback-stage events (exception, ertn, TLB-op refetch) and issues a single-cycle pipeline flush.
- Tracks outstanding instruction-fetch bus transactions so stale responses are dropped.
- Hands the new fetch PC to the fetch stage with a valid/ready handshake once draining completes.

Parameters:
- MAX_OUTST, 3, maximum in-flight instruction read requests.
- CNT_W, 2, width of the outstanding/drop counters; must hold MAX_OUTST.
- ECODE_TLBR, 6'h3F, exception code that selects the TLB-refill entry.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- wb_ex  in  1  writeback exception this cycle, already qualified by ws_valid
- ertn_flush  in  1  writeback ertn this cycle
- wb_refetch_flush  in  1  writeback tlb/csr refetch request this cycle
- wb_pc  in  32  PC of the writeback instruction
- wb_ecode  in  6  exception code of wb_ex
- csr_eentry  in  32  CSR.EENTRY
- csr_tlbrentry  in  32  CSR.TLBRENTRY
- csr_era  in  32  CSR.ERA
- inst_req_fire  in  1  instruction read request accepted by the bus
- inst_resp_fire  in  1  instruction read data beat accepted (single beat)
- flush  out  1  clear valid in IF/ID/EX/MEM
- inst_resp_drop  out  1  discard the current inst_resp_fire beat
- fetch_stall  out  1  fetch must not issue a new request
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepted redirect_pc
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous, active-low. All state regs clear on reset.
- Reset values: state=IDLE, outst_cnt=0, drop_cnt=0, tgt_pc=0. Outputs: flush=0, redirect_valid=0, fetch_stall=0, busy=0, inst_resp_drop=0, redirect_pc=0.
- trig = wb_ex | ertn_flush | wb_refetch_flush. flush = trig, combinational, same cycle.
- Target priority is wb_ex > ertn_flush > refetch:
  - wb_ex with wb_ecode==ECODE_TLBR → csr_tlbrentry.
  - wb_ex otherwise → csr_eentry.
  - ertn_flush → csr_era.
  - refetch → wb_pc+32'd4, mod 2^32.
- tgt_pc latches the target on the trigger edge. redirect_pc = tgt_pc.
- outst_cnt_next = outst_cnt + inst_req_fire - inst_resp_fire.
  - A response with outst_cnt==0 is a protocol error; simulation asserts.
  - A request while outst_cnt==MAX_OUTST is a protocol error; simulation asserts.
- inst_resp_drop = inst_resp_fire & (trig | drop_cnt!=0).
- drop_cnt update:
  - If trig: drop_cnt <= outst_cnt_next.
  - Else if inst_resp_fire & drop_cnt!=0: decrement.
- fetch_stall = (outst_cnt==MAX_OUTST) | state==DRAIN | state==REDIR | trig.
- FSM:
  - IDLE: on trig → DRAIN if outst_cnt_next!=0, else → REDIR.
  - DRAIN: when drop_cnt==1 & inst_resp_fire → REDIR.
  - REDIR: redirect_valid=1; on redirect_ready → IDLE. redirect_pc stays stable while valid & !ready.
- A trig in any non-IDLE state restarts the sequence with the same rules: new target, drop_cnt reloaded. A retriggered REDIR with no outstanding goes to REDIR again.
- Latency: with no outstanding requests, trigger at cycle T gives redirect_valid at T+1. Each outstanding response adds at least one cycle.
- A request accepted in the trigger cycle is counted as stale.
- Reset mid-operation: immediate return to reset values; pending drops are forgotten. The bus is reset together with the core.

Decomposition:
- Shared header head.h holds ECODE_TLBR and the FSM state encodings IDLE/DRAIN/REDIR (2 bits).
- One natural sub-module, outst_tracker: outst_cnt, drop_cnt, inst_resp_drop and the saturation checks.
- The top level holds the FSM and target selection.

Test Plan:
- Idle exception, 0 outstanding, wb_ex=1, wb_ecode=0x0B, csr_eentry=0x1C008000 → flush=1 at T; redirect_valid=1, redirect_pc=0x1C008000 at T+1; ready at T+2 → IDLE.
- TLBR: wb_ex, ecode=0x3F, tlbrentry=0x1C00F000, 2 outstanding → 2 responses dropped (inst_resp_drop=1 each), fetch_stall=1 throughout, redirect_valid after the 2nd drop.
- Refetch at wb_pc=0xFFFFFFFC → redirect_pc=0x00000000 (wrap).
- Simultaneous wb_ex and ertn_flush, era=0x1C001234 → target is eentry, not era.
- Trigger while a response arrives in the same cycle with outst_cnt=1, plus a request → that response is dropped, drop_cnt=1; the next response is dropped; then REDIR.
- Retrigger in REDIR with redirect_ready=0, ertn, era=0x1C002000 → redirect_pc updates to 0x1C002000; resetn=0 mid-DRAIN → all outputs 0 immediately.
